// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, NOP control fields and counter sizing for pipe_sequencer
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    FILL     = 3'd0,
    RUN      = 3'd1,
    CTRL_EXE = 3'd2,
    CTRL_WB  = 3'd3,
    REFILL   = 3'd4,
    MUL_WAIT = 3'd5
  } seq_state_e;
  typedef struct packed {
    logic has_wb;
    logic is_jump;
    logic is_mult;
  } ctrl_fields_t;
  localparam ctrl_fields_t NOP_FIELDS = '{has_wb: 1'b0, is_jump: 1'b0, is_mult: 1'b0};
  function automatic int cnt_w(input int lat);
    return lat > 1 ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/stall_counter.sv
// stall_counter: loadable down-counter that saturates at zero, timing the multiplier wait
module stall_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = cnt_w(MUL_LAT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? W'(MUL_LAT - 1) : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: single scheduler driving PC, Dec/Exe, Exe/WB and register-bank enables
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       hold,
  input  logic       dec_has_stall,
  input  logic       dec_is_mult,
  input  logic       exe_is_jump,
  input  logic       exe_has_stall,
  input  logic       exe_flag_z,
  input  logic       wb_has_wb,
  output logic       pc_wr,
  output logic       pc_sel_ext,
  output logic       dec_exe_wr,
  output logic       dec_exe_bubble,
  output logic       exe_wb_wr,
  output logic       reg_bank_wr,
  output logic [2:0] seq_state
);
  seq_state_e state_q, state_d;
  logic taken_q, taken_d, dv_q, dv_d, wv_q, wv_d;
  logic mul_load, mul_dec, mul_zero;
  stall_counter #(.MUL_LAT(MUL_LAT)) u_stall (
    .CLK(CLK), .RST(RST), .load(mul_load), .dec(mul_dec), .zero(mul_zero)
  );
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    pc_wr = 1'b0;
    pc_sel_ext = 1'b0;
    dec_exe_wr = 1'b0;
    dec_exe_bubble = 1'b0;
    exe_wb_wr = 1'b0;
    mul_load = 1'b0;
    mul_dec = 1'b0;
    case (state_q)
      FILL: state_d = RUN;
      RUN: begin
        dec_exe_wr = 1'b1;
        exe_wb_wr = 1'b1;
        pc_wr = !(dec_has_stall || dec_is_mult);
        mul_load = !dec_has_stall && dec_is_mult;
        state_d = dec_has_stall ? CTRL_EXE : dec_is_mult ? MUL_WAIT : RUN;
      end
      CTRL_EXE: begin
        dec_exe_wr = 1'b1;
        dec_exe_bubble = 1'b1;
        exe_wb_wr = 1'b1;
        taken_d = exe_is_jump || (exe_has_stall && exe_flag_z);
        state_d = CTRL_WB;
      end
      CTRL_WB: begin
        dec_exe_wr = 1'b1;
        dec_exe_bubble = 1'b1;
        exe_wb_wr = 1'b1;
        pc_wr = taken_q;
        pc_sel_ext = taken_q;
        state_d = taken_q ? REFILL : RUN;
      end
      REFILL: begin
        dec_exe_wr = 1'b1;
        dec_exe_bubble = 1'b1;
        exe_wb_wr = 1'b1;
        state_d = RUN;
      end
      MUL_WAIT: begin
        pc_wr = mul_zero;
        dec_exe_wr = mul_zero;
        exe_wb_wr = mul_zero;
        mul_dec = !mul_zero;
        state_d = mul_zero ? RUN : MUL_WAIT;
      end
      default: state_d = FILL;
    endcase
    // Freeze is total: no enable fires and no state element advances.
    if (hold) begin
      state_d = state_q;
      taken_d = taken_q;
      pc_wr = 1'b0;
      pc_sel_ext = 1'b0;
      dec_exe_wr = 1'b0;
      dec_exe_bubble = 1'b0;
      exe_wb_wr = 1'b0;
      mul_load = 1'b0;
      mul_dec = 1'b0;
    end
    dv_d = dec_exe_wr ? !dec_exe_bubble : dv_q;
    wv_d = exe_wb_wr ? dv_q : wv_q;
    reg_bank_wr = wv_q && wb_has_wb && !hold && state_q != FILL;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= FILL;
      taken_q <= 1'b0;
      dv_q <= 1'b0;
      wv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      dv_q <= dv_d;
      wv_q <= wv_d;
    end
  end
  assign seq_state = state_q;
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: directed stimulus, schedule-queue reference model and literal spot checks
module tb_pipe_sequencer;
  localparam int LAT = 3;
  logic CLK = 0, RST = 0, hold = 0;
  logic dec_has_stall = 0, dec_is_mult = 0, exe_is_jump = 0, exe_has_stall = 0;
  logic exe_flag_z = 0, wb_has_wb = 0;
  logic pc_wr, pc_sel_ext, dec_exe_wr, dec_exe_bubble, exe_wb_wr, reg_bank_wr;
  logic [2:0] seq_state;
  int checks = 0, failures = 0;

  pipe_sequencer #(.MUL_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .hold(hold),
    .dec_has_stall(dec_has_stall), .dec_is_mult(dec_is_mult),
    .exe_is_jump(exe_is_jump), .exe_has_stall(exe_has_stall),
    .exe_flag_z(exe_flag_z), .wb_has_wb(wb_has_wb),
    .pc_wr(pc_wr), .pc_sel_ext(pc_sel_ext), .dec_exe_wr(dec_exe_wr),
    .dec_exe_bubble(dec_exe_bubble), .exe_wb_wr(exe_wb_wr),
    .reg_bank_wr(reg_bank_wr), .seq_state(seq_state)
  );

  always #5 CLK = ~CLK;

  // One cycle of expected behaviour: pc_wr, pc_sel_ext, dec_exe_wr, bubble, exe_wb_wr, state.
  typedef struct packed {logic pc_wr, sel, dw, bub, ew; logic [2:0] st;} rec_t;
  localparam rec_t FILL_R = 8'b00000_000;
  localparam rec_t CE_R   = 8'b00111_010;
  localparam rec_t RF_R   = 8'b00111_100;
  localparam rec_t MW_R   = 8'b00000_101;
  localparam rec_t MR_R   = 8'b10101_101;
  rec_t plan[$];
  bit dslot, wslot;

  always @(negedge CLK) begin : model
    rec_t e;
    logic erbw;
    logic [8:0] got, want;
    bit was_run, taken;
    got = {pc_wr, pc_sel_ext, dec_exe_wr, dec_exe_bubble, exe_wb_wr, reg_bank_wr, seq_state};
    if (!RST) begin
      plan = {};
      plan.push_back(FILL_R);
      dslot = 0;
      wslot = 0;
      want = '0;
    end else begin
      was_run = plan.size() == 0;
      e = was_run ? {!(dec_has_stall || dec_is_mult), 1'b0, 1'b1, 1'b0, 1'b1, 3'd1} : plan[0];
      erbw = wslot && wb_has_wb && e.st != 3'd0 && !hold;
      want = hold ? {6'b0, e.st} : {e.pc_wr, e.sel, e.dw, e.bub, e.ew, erbw, e.st};
      if (!hold) begin
        if (!was_run) void'(plan.pop_front());
        else if (dec_has_stall) plan.push_back(CE_R);
        else if (dec_is_mult) begin
          repeat (LAT - 1) plan.push_back(MW_R);
          plan.push_back(MR_R);
        end
        if (e.st == 3'd2) begin
          taken = exe_is_jump || (exe_has_stall && exe_flag_z);
          plan.push_back({taken, taken, 3'b111, 3'd3});
          if (taken) plan.push_back(RF_R);
        end
        if (e.ew) wslot = dslot;
        if (e.dw) dslot = !e.bub;
      end
    end
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t pc/sel/dw/bub/ew/rbw/state got=%b want=%b", $time, got, want);
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) begin
      step();
      lit("reset_pc_wr", pc_wr, 0);
      lit("reset_dec_exe_wr", dec_exe_wr, 0);
      lit("reset_state", seq_state, 0);
    end
    RST = 1;
    #1 lit("fill_state", seq_state, 0);
    lit("fill_pc_wr", pc_wr, 0);
    step(); wb_has_wb = 1;
    #1 lit("run_state", seq_state, 1);
    lit("run_pc_wr", pc_wr, 1);
    lit("run_dec_exe_wr", dec_exe_wr, 1);
    n = reg_bank_wr;
    step(); #1 lit("rbw_not_early", reg_bank_wr, 0);
    n += reg_bank_wr;
    repeat (4) begin step(); #1 n += reg_bank_wr; end
    lit("rbw_pulse_count", n, 4);
    step(); hold = 1;
    #1 lit("hold_run_pc_wr", pc_wr, 0);
    lit("hold_run_rbw", reg_bank_wr, 0);
    step(); hold = 0;
    // taken jump
    dec_has_stall = 1;
    #1 lit("jmp_n_pc_wr", pc_wr, 0);
    step(); dec_has_stall = 0; exe_is_jump = 1;
    #1 lit("jmp_n1_state", seq_state, 2);
    lit("jmp_n1_bubble", dec_exe_bubble, 1);
    step(); exe_is_jump = 0;
    #1 lit("jmp_n2_pc_wr", pc_wr, 1);
    lit("jmp_n2_sel", pc_sel_ext, 1);
    step(); #1 lit("jmp_n3_state", seq_state, 4);
    lit("jmp_n3_rbw", reg_bank_wr, 0);
    step(); #1 lit("jmp_n4_state", seq_state, 1);
    lit("jmp_n4_rbw", reg_bank_wr, 0);
    // not-taken branch
    dec_has_stall = 1;
    step(); dec_has_stall = 0; exe_has_stall = 1; exe_flag_z = 0;
    step(); exe_has_stall = 0;
    #1 lit("nt_n2_pc_wr", pc_wr, 0);
    lit("nt_n2_sel", pc_sel_ext, 0);
    lit("nt_n2_state", seq_state, 3);
    step(); #1 lit("nt_n3_state", seq_state, 1);
    lit("nt_n3_pc_wr", pc_wr, 1);
    // taken branch
    dec_has_stall = 1;
    step(); dec_has_stall = 0; exe_has_stall = 1; exe_flag_z = 1;
    step(); exe_has_stall = 0; exe_flag_z = 0;
    #1 lit("tb_n2_sel", pc_sel_ext, 1);
    step(); #1 lit("tb_n3_state", seq_state, 4);
    step();
    // multiply
    dec_is_mult = 1;
    #1 lit("mul_n_pc_wr", pc_wr, 0);
    lit("mul_n_dec_exe_wr", dec_exe_wr, 1);
    step(); dec_is_mult = 0;
    #1 lit("mul_n1_state", seq_state, 5);
    lit("mul_n1_ew", exe_wb_wr, 0);
    lit("mul_n1_dw", dec_exe_wr, 0);
    step(); #1 lit("mul_n2_ew", exe_wb_wr, 0);
    step(); #1 lit("mul_n3_ew", exe_wb_wr, 1);
    lit("mul_n3_pc_wr", pc_wr, 1);
    lit("mul_n3_dw", dec_exe_wr, 1);
    step(); #1 lit("mul_n4_state", seq_state, 1);
    // multiply with hold
    dec_is_mult = 1;
    step(); dec_is_mult = 0; hold = 1;
    #1 lit("mh_hold_pc_wr", pc_wr, 0);
    lit("mh_hold_state", seq_state, 5);
    step(); #1 lit("mh_hold2_ew", exe_wb_wr, 0);
    step(); hold = 0;
    #1 lit("mh_r1_ew", exe_wb_wr, 0);
    step(); #1 lit("mh_r2_ew", exe_wb_wr, 0);
    step(); #1 lit("mh_r3_ew", exe_wb_wr, 1);
    step(); #1 lit("mh_run_state", seq_state, 1);
    // reset during CTRL_WB of a taken jump
    dec_has_stall = 1;
    step(); dec_has_stall = 0; exe_is_jump = 1;
    step(); exe_is_jump = 0;
    #1 lit("rst_pre_state", seq_state, 3);
    lit("rst_pre_pc_wr", pc_wr, 1);
    #1 RST = 0;
    #1 lit("rst_async_state", seq_state, 0);
    lit("rst_async_pc_wr", pc_wr, 0);
    lit("rst_async_sel", pc_sel_ext, 0);
    lit("rst_async_dw", dec_exe_wr, 0);
    repeat (2) step();
    RST = 1;
    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
